// File: rtl/org_lcu_loader.sv
// org_lcu_loader: streams a 64x64 luma LCU into the original-pixel line buffer.
// Pairs consecutive 16-pixel raster beats into 32-pixel lines. Each line is
// written once at address {row[5], half, row[4:0]}. Writes are held off while
// the consumer owns the single-port buffer (wr_hold_i).
// Optional feature: define ORG_LOADER_CLIP_EN for partial LCUs. The loader then
// zero-masks pixels beyond the width and self-generates zero lines below the
// height.

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module org_lcu_loader (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        in_valid_i,
  input  logic [`PIXEL_WIDTH*16-1:0]  in_data_i,
  output logic                        in_ready_o,
`ifdef ORG_LOADER_CLIP_EN
  input  logic [6:0]                  lcu_w_i,
  input  logic [6:0]                  lcu_h_i,
`endif
  input  logic                        wr_hold_i,
  output logic                        a_wen_o,
  output logic [6:0]                  a_addr_o,
  output logic [`PIXEL_WIDTH*32-1:0]  a_wdata_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned PW = `PIXEL_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t             state_q;
  logic [7:0]         beat_q;
  logic [PW*16-1:0]   half_q;
  logic               pend_vld_q;
  logic [6:0]         pend_addr_q;
  logic [PW*32-1:0]   pend_data_q;

  logic               accept;
  logic               wr_fire;
  logic               pend_free;
  logic               gen;
  logic [PW*32-1:0]   line_raw;
  logic [PW*32-1:0]   line_d;
  logic [6:0]         line_addr;

  assign line_raw  = {half_q, in_data_i};
  assign line_addr = {beat_q[7], beat_q[1], beat_q[6:2]};
  assign wr_fire   = pend_vld_q & ~wr_hold_i;
  assign pend_free = ~pend_vld_q | ~wr_hold_i;
  assign accept    = in_valid_i & in_ready_o;

`ifdef ORG_LOADER_CLIP_EN
  logic [6:0] lcu_w_q;
  logic [6:0] lcu_h_q;

  // Once the row counter reaches the LCU height, lines are self-generated as zero.
  assign gen = (state_q == LOAD) && ({1'b0, beat_q[7:2]} >= lcu_h_q);

  // Zero every pixel at or beyond the LCU width; pixel 0 sits in the MSBs.
  always_comb begin
    line_d = line_raw;
    for (int unsigned i = 0; i < 32; i++) begin
      if ({1'b0, beat_q[1], 5'(i)} >= lcu_w_q)
        line_d[(31-i)*PW +: PW] = '0;
    end
  end

  // Latch the LCU dimensions when a load starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcu_w_q <= 7'd64;
      lcu_h_q <= 7'd64;
    end else if (state_q == IDLE && start_i) begin
      lcu_w_q <= lcu_w_i;
      lcu_h_q <= lcu_h_i;
    end
  end
`else
  assign gen    = 1'b0;
  assign line_d = line_raw;
`endif

  // Control FSM, beat counter, half-line staging and pending-line register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      half_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      if (wr_fire)
        pend_vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= LOAD;
            beat_q  <= '0;
          end
        end
        LOAD: begin
          if (gen) begin
            // One zero line per cycle whenever the pending slot is free or draining.
            if (pend_free) begin
              pend_vld_q  <= 1'b1;
              pend_addr_q <= line_addr;
              pend_data_q <= '0;
              beat_q      <= beat_q + 8'd2;
              if (beat_q == 8'd254)
                state_q <= FLUSH;
            end
          end else if (accept) begin
            beat_q <= beat_q + 8'd1;
            if (!beat_q[0]) begin
              half_q <= in_data_i;
            end else begin
              pend_vld_q  <= 1'b1;
              pend_addr_q <= line_addr;
              pend_data_q <= line_d;
            end
            if (beat_q == 8'd255)
              state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (wr_fire) begin
            state_q <= IDLE;
            beat_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // An odd beat may only overwrite the pending line if that line drains this cycle.
  assign in_ready_o = (state_q == LOAD) && !gen && !(beat_q[0] && pend_vld_q && wr_hold_i);
  assign a_wen_o    = wr_fire;
  assign a_addr_o   = pend_addr_q;
  assign a_wdata_o  = pend_data_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == FLUSH) && wr_fire;

endmodule

// File: tb/tb_org_lcu_loader.sv
// Directed testbench for org_lcu_loader (default 64x64 build, 8-bit pixels).
module tb_org_lcu_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         in_valid_i;
  logic [127:0] in_data_i;
  logic         in_ready_o;
  logic         wr_hold_i;
  logic         a_wen_o;
  logic [6:0]   a_addr_o;
  logic [255:0] a_wdata_o;
  logic         busy_o;
  logic         done_o;
`ifdef ORG_LOADER_CLIP_EN
  logic [6:0]   lcu_w_i = 7'd64;
  logic [6:0]   lcu_h_i = 7'd64;
`endif

  org_lcu_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
`ifdef ORG_LOADER_CLIP_EN
    .lcu_w_i    (lcu_w_i),
    .lcu_h_i    (lcu_h_i),
`endif
    .wr_hold_i  (wr_hold_i),
    .a_wen_o    (a_wen_o),
    .a_addr_o   (a_addr_o),
    .a_wdata_o  (a_wdata_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int     cyc = 0;
  int     wr_idx;
  int     n_done;
  int     done_cyc;
  int     last_acc_cyc;
  logic   seen [128];
  logic   hold_rand = 1'b0;
  logic   hold_dir  = 1'b0;
  logic   acc, s_ready, s_wen, s_busy;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive hold, sample just before the rising edge, return at the next falling edge.
  task automatic step();
    logic [7:0]   b0;
    logic [6:0]   exp_addr;
    int           row, half;
    wr_hold_i = hold_rand ? ($urandom_range(0, 3) == 0) : hold_dir;
    #4;
    s_ready = in_ready_o;
    s_wen   = a_wen_o;
    s_busy  = busy_o;
    acc     = in_valid_i & in_ready_o;
    if (a_wen_o) begin
      row      = wr_idx >> 1;
      half     = wr_idx & 1;
      exp_addr = 7'(((row >> 5) << 6) | (half << 5) | (row & 31));
      b0       = 8'(2 * wr_idx);
      check("wr_addr", a_addr_o, exp_addr);
      check("wr_data", a_wdata_o, {{16{b0}}, {16{b0 + 8'd1}}});
      check("addr_unique", seen[a_addr_o], 1'b0);
      seen[a_addr_o] = 1'b1;
      wr_idx++;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (acc) last_acc_cyc = cyc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic begin_lcu();
    wr_idx = 0;
    n_done = 0;
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    in_valid_i = 1'b0;
    start_i    = 1'b1;
    step();
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1'b1);
  endtask

  // Offer beats [from, to); start_at pulses start_i once while that beat is offered.
  task automatic load(input int from, input int to, input logic gaps, input int start_at);
    int k = from;
    int guard = 0;
    logic pulsed = 1'b0;
    while (k < to && guard < 5000) begin
      in_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data_i  = {16{8'(k)}};
      start_i    = (k == start_at) && !pulsed;
      if (start_i) pulsed = 1'b1;
      step();
      if (acc) k++;
      guard++;
    end
    in_valid_i = 1'b0;
    start_i    = 1'b0;
    if (guard >= 5000) check("beat_timeout", k, to);
  endtask

  task automatic finish_lcu();
    int guard = 0;
    while (n_done == 0 && guard < 200) begin
      step();
      guard++;
    end
    check("done_seen", n_done, 1);
    step();
    check("wr_count", wr_idx, 128);
    check("done_count", n_done, 1);
    check("busy_idle", s_busy, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    wr_hold_i  = 1'b0;
    wr_idx     = 0;
    n_done     = 0;
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    @(negedge clk);
    step();
    step();
    check("rst_ready", in_ready_o, 1'b0);
    check("rst_wen",   a_wen_o, 1'b0);
    check("rst_addr",  a_addr_o, 7'd0);
    check("rst_wdata", a_wdata_o, 256'd0);
    check("rst_busy",  busy_o, 1'b0);
    check("rst_done",  done_o, 1'b0);
    rst = 1'b0;

    // Valid offered while idle is not accepted.
    in_valid_i = 1'b1;
    step();
    check("idle_ready", s_ready, 1'b0);
    in_valid_i = 1'b0;

    // Full stream, no stalls or hold.
    begin_lcu();
    load(0, 256, 1'b0, -1);
    finish_lcu();
    check("done_latency", done_cyc, last_acc_cyc + 1);

    // Hold for 5 cycles while line 0 is pending and beats 2/3 are offered.
    begin_lcu();
    load(0, 2, 1'b0, -1);
    hold_dir   = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = {16{8'd2}};
    step();
    check("hold_wen_c1", s_wen, 1'b0);
    check("hold_even_ready", s_ready, 1'b1);
    in_data_i = {16{8'd3}};
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_wen", s_wen, 1'b0);
      check("hold_odd_ready", s_ready, 1'b0);
    end
    hold_dir = 1'b0;
    step();
    check("hold_release_wen", s_wen, 1'b1);
    check("hold_release_ready", s_ready, 1'b1);
    load(4, 256, 1'b0, -1);
    finish_lcu();

    // Random input gaps and random hold.
    hold_rand = 1'b1;
    begin_lcu();
    load(0, 256, 1'b1, -1);
    finish_lcu();
    hold_rand = 1'b0;

    // Reset after 100 beats, then restart from beat 0.
    begin_lcu();
    load(0, 100, 1'b0, -1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ready", in_ready_o, 1'b0);
    check("midrst_wen",   a_wen_o, 1'b0);
    check("midrst_addr",  a_addr_o, 7'd0);
    check("midrst_wdata", a_wdata_o, 256'd0);
    check("midrst_busy",  busy_o, 1'b0);
    check("midrst_done",  done_o, 1'b0);
    begin_lcu();
    load(0, 256, 1'b0, -1);
    finish_lcu();

    // start_i pulsed mid-load is ignored.
    begin_lcu();
    load(0, 256, 1'b0, 50);
    finish_lcu();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/org_lcu_loader.md
# org_lcu_loader

Upstream loader for the original-pixel line buffer. Accepts a 64x64 luma LCU as a raster stream of 16-pixel beats and pairs consecutive beats into 32-pixel lines. Issues one single-cycle write per line on the buffer's write port at address {row[5], half, row[4:0]}. Holds writes while the consumer owns the single-port buffer.

## Interface
Parameters:
- none. Pixel width is taken from `PIXEL_WIDTH` in enc_defines.v.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous and active-high
- start_i  in  1  one-cycle pulse that begins an LCU load; ignored unless the FSM is in IDLE
- in_valid_i  in  1  input beat valid
- in_data_i  in  PIXEL_WIDTH*16  16 pixels; leftmost pixel in the MSBs
- in_ready_o  out  1  beat accepted when in_valid_i & in_ready_o
- wr_hold_i  in  1  consumer reading the buffer; forces a_wen_o=0
- a_wen_o  out  1  buffer write enable
- a_addr_o  out  7  buffer write address
- a_wdata_o  out  PIXEL_WIDTH*32  32-pixel line; leftmost pixel in the MSBs
- busy_o  out  1  high in LOAD and FLUSH
- done_o  out  1  one-cycle pulse when the LCU is fully written

## Operation
- FSM states: IDLE, LOAD, FLUSH.
  - IDLE to LOAD on start_i.
  - LOAD to FLUSH when beat 255 is accepted.
  - FLUSH to IDLE when the pending line is written. done_o pulses in the same cycle as that last write.
- Beat counter `beat[7:0]`:
  - row = beat[7:2], half = beat[1], odd = beat[0].
  - Increments on each accepted beat and wraps to 0 on return to IDLE.
- Even beat: stored in the 16-pixel half register.
- Odd beat: {half_reg, in_data_i} is loaded into the pending line register. pend_vld is set and the address {row[5], half, row[4:0]} is latched.
- a_wen_o = pend_vld & ~wr_hold_i. This is combinational from registered state and the hold input. pend_vld clears on the write cycle.
- in_ready_o = (state==LOAD) & ~(odd & pend_vld & wr_hold_i).
  - An even beat is always accepted in LOAD.
  - An odd beat is accepted while a line is pending only if that line drains in the same cycle.
- a_addr_o and a_wdata_o hold the pending values whenever pend_vld=1. They are don't-care otherwise.
- start_i during LOAD or FLUSH: ignored.
- in_valid_i outside LOAD: no beat is accepted.
- Reset mid-load: everything returns to reset values. The partial LCU is discarded and no further writes are issued.
- Reset values: state=IDLE, beat=0, pend_vld=0, in_ready_o=0, a_wen_o=0, a_addr_o=0, a_wdata_o=0, busy_o=0, done_o=0.

## Timing
- Odd beat accepted at cycle N: with wr_hold_i=0 at N+1, a_wen_o=1 at N+1.
- Each cycle of wr_hold_i delays the write by one cycle.
- Sustained throughput: 1 beat/cycle, 1 write every 2 cycles.
- Minimum LCU time with no hold and no input stalls: 256 cycles from the first accepted beat to the last beat, plus 1 cycle to the final write and done_o.
- Exactly 128 writes per LCU. Each address 0..127 is written exactly once.

## Configuration
- `ORG_LOADER_CLIP_EN` defined: adds inputs lcu_w_i[6:0] and lcu_h_i[6:0]. Both are valid widths/heights 8..64 in multiples of 8, sampled on start_i.
  - Pixels with x >= width are written as 0.
  - Rows >= height are not sent by upstream. Once beat reaches row=height, the loader stops accepting beats (in_ready_o=0) and self-generates zero lines for the remaining addresses.
  - Self-generated lines issue one write per cycle, subject to wr_hold_i.
  - done_o pulses after the 128th write.
- `ORG_LOADER_CLIP_EN` undefined: full 64x64 only. No extra ports.

## Test plan
- Full stream, no stalls or hold:
  - 256 beats, where beat k carries pixel value k replicated.
  - Required: 128 writes. Address for row r, half h = {r[5], h, r[4:0]}; data = {2k, 2k+1}.
  - done_o pulses one cycle after the last beat.
- wr_hold_i high for 5 cycles while a line is pending and the next odd beat is offered:
  - Required: a_wen_o stays 0 for those 5 cycles and in_ready_o is low for the odd beat.
  - The write appears on the cycle hold drops. No data loss or duplication.
- Random in_valid_i gaps and random hold:
  - Required: the write sequence (address, data) matches the scoreboard, and no address repeats.
- rst asserted after 100 beats, then a restart:
  - Required: all outputs return to reset values the next cycle.
  - A new start_i loads a complete LCU correctly from beat 0.
- start_i pulsed during LOAD:
  - Required: ignored. Beat count is unaffected and exactly one done_o appears.
- With `ORG_LOADER_CLIP_EN`, lcu_w_i=40, lcu_h_i=24:
  - Only 96 beats are consumed.
  - Rows 0–23, half 1: pixels 8..31 are zero.
  - Rows 24–63: all zero, self-generated.
  - Required: 128 writes, done_o once.
